axil_master: RTL and testbench

AXIL_MASTER -- requirements
Module: axil_master

---
 rtl/axil_master_if.sv | 70 +++++++
 rtl/axil_master.sv | 161 ++++++++++++++++
 tb/tb_axil_master.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_master_if.sv
// Command/response port plus AXI-Lite master bus for axil_master.
// Signal directions in the master modport are as seen by the master.
interface axil_master_if #(
    parameter int CFGAW = 32,
    parameter int CFGDW = 32
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_we;
    logic [CFGAW-1:0]   cmd_addr;
    logic [CFGDW-1:0]   cmd_wdata;

    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_we;
    logic [CFGDW-1:0]   rsp_data;
    logic [1:0]         rsp_resp;

    logic [CFGAW-1:0]   m_axil_awaddr;
    logic               m_axil_awvalid;
    logic               m_axil_awready;
    logic [CFGDW-1:0]   m_axil_wdata;
    logic [CFGDW/8-1:0] m_axil_wstrb;
    logic               m_axil_wvalid;
    logic               m_axil_wready;
    logic [1:0]         m_axil_bresp;
    logic               m_axil_bvalid;
    logic               m_axil_bready;
    logic [CFGAW-1:0]   m_axil_araddr;
    logic               m_axil_arvalid;
    logic               m_axil_arready;
    logic [CFGDW-1:0]   m_axil_rdata;
    logic [1:0]         m_axil_rresp;
    logic               m_axil_rvalid;
    logic               m_axil_rready;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_we, rsp_data, rsp_resp,
        input  rsp_ready,
        output m_axil_awaddr, m_axil_awvalid,
        input  m_axil_awready,
        output m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
        input  m_axil_wready,
        input  m_axil_bresp, m_axil_bvalid,
        output m_axil_bready,
        output m_axil_araddr, m_axil_arvalid,
        input  m_axil_arready,
        input  m_axil_rdata, m_axil_rresp, m_axil_rvalid,
        output m_axil_rready
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_we, rsp_data, rsp_resp,
        output rsp_ready,
        input  m_axil_awaddr, m_axil_awvalid,
        output m_axil_awready,
        input  m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
        output m_axil_wready,
        output m_axil_bresp, m_axil_bvalid,
        input  m_axil_bready,
        input  m_axil_araddr, m_axil_arvalid,
        output m_axil_arready,
        output m_axil_rdata, m_axil_rresp, m_axil_rvalid,
        input  m_axil_rready
    );
endinterface

// File: rtl/axil_master.sv
// Single-outstanding AXI-Lite master: one command in, one AXI-Lite
// transaction out, one response back.
module axil_master #(
    parameter int CFGAW = 32,
    parameter int CFGDW = 32
) (
    input logic           clk,
    input logic           rst,
    axil_master_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic             aw_done_q;
    logic             w_done_q;
    logic [CFGAW-1:0] addr_q;
    logic [CFGDW-1:0] wdata_q;
    logic             we_q;
    logic [CFGDW-1:0] rsp_data_q;
    logic [1:0]       rsp_resp_q;

    logic             cmd_hs;
    logic             aw_hs;
    logic             w_hs;
    logic             b_hs;
    logic             ar_hs;
    logic             r_hs;
    logic             rsp_hs;
    logic             aw_fin;
    logic             w_fin;

    assign cmd_hs = bus.cmd_valid && bus.cmd_ready;
    assign aw_hs  = bus.m_axil_awvalid && bus.m_axil_awready;
    assign w_hs   = bus.m_axil_wvalid && bus.m_axil_wready;
    assign b_hs   = bus.m_axil_bvalid && bus.m_axil_bready;
    assign ar_hs  = bus.m_axil_arvalid && bus.m_axil_arready;
    assign r_hs   = bus.m_axil_rvalid && bus.m_axil_rready;
    assign rsp_hs = bus.rsp_valid && bus.rsp_ready;

    // A channel counts as finished once it handshook earlier or does now.
    assign aw_fin = aw_done_q || aw_hs;
    assign w_fin  = w_done_q || w_hs;

    // Ready is gated by reset so it stays low while reset is held.
    assign bus.cmd_ready      = (state_q == IDLE) && rst;

    assign bus.m_axil_awvalid = (state_q == WR_ADDR) && !aw_done_q;
    assign bus.m_axil_wvalid  = (state_q == WR_ADDR) && !w_done_q;
    assign bus.m_axil_bready  = (state_q == WR_RESP);
    assign bus.m_axil_arvalid = (state_q == RD_ADDR);
    assign bus.m_axil_rready  = (state_q == RD_DATA);

    assign bus.m_axil_awaddr  = addr_q;
    assign bus.m_axil_araddr  = addr_q;
    assign bus.m_axil_wdata   = wdata_q;
    assign bus.m_axil_wstrb   = '1;

    assign bus.rsp_valid      = (state_q == RSP);
    assign bus.rsp_we         = we_q;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.rsp_resp       = rsp_resp_q;

    // Next-state decode for the transaction sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    state_d = bus.cmd_we ? WR_ADDR : RD_ADDR;
                end
            end
            WR_ADDR: begin
                if (aw_fin && w_fin) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_d = RSP;
                end
            end
            RD_ADDR: begin
                if (ar_hs) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                if (rsp_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the command so the bus sees stable address/data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (cmd_hs) begin
            addr_q  <= bus.cmd_addr;
            wdata_q <= bus.cmd_wdata;
            we_q    <= bus.cmd_we;
        end
    end

    // Track AW and W independently so each valid drops on its own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (state_d != WR_ADDR) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            aw_done_q <= aw_fin;
            w_done_q  <= w_fin;
        end
    end

    // Latch the B or R result for the response port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_data_q <= '0;
            rsp_resp_q <= 2'b00;
        end else if (b_hs) begin
            rsp_data_q <= '0;
            rsp_resp_q <= bus.m_axil_bresp;
        end else if (r_hs) begin
            rsp_data_q <= bus.m_axil_rdata;
            rsp_resp_q <= bus.m_axil_rresp;
        end
    end

endmodule

// File: tb/tb_axil_master.sv
// Bench for axil_master: directed scenarios plus randomized traffic
// against a delay-programmable AXI-Lite responder and a memory model.
module tb_axil_master;

    logic clk;
    logic rst;

    axil_master_if #(.CFGAW(32), .CFGDW(32)) bus ();

    axil_master #(.CFGAW(32), .CFGDW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests;
    int fails;
    int cyc;
    int acc;

    // responder knobs
    int       aw_dly, w_dly, ar_dly, b_dly, r_dly;
    logic [1:0] bresp_cfg, rresp_cfg;

    // responder state
    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic        aw_got, w_got, ar_got;
    int          aw_cnt, w_cnt, ar_cnt, bwait, rwait;
    logic        p_aw, p_w, p_ar, p_b, p_r;
    logic        pv_awvalid, pv_wvalid, pv_arvalid;
    logic [31:0] pv_awaddr, pv_wdata, pv_araddr;
    logic [31:0] last_awaddr, last_wdata, last_araddr;
    int          b_hs, r_hs, ar_high, viol;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic resp_clear();
        bus.m_axil_awready = 0; bus.m_axil_wready = 0;
        bus.m_axil_arready = 0;
        bus.m_axil_bvalid = 0;  bus.m_axil_bresp = 0;
        bus.m_axil_rvalid = 0;  bus.m_axil_rresp = 0;
        bus.m_axil_rdata = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; bwait = 0; rwait = 0;
        p_aw = 0; p_w = 0; p_ar = 0; p_b = 0; p_r = 0;
        pv_awvalid = 0; pv_wvalid = 0; pv_arvalid = 0;
        pv_awaddr = 0; pv_wdata = 0; pv_araddr = 0;
    endtask

    // Responder and protocol monitor, stepping once per cycle.
    initial begin
        b_hs = 0; r_hs = 0; ar_high = 0; viol = 0;
        last_awaddr = 0; last_wdata = 0; last_araddr = 0;
        resp_clear();
        forever begin
            @(negedge clk);
            if (!rst) begin
                resp_clear();
            end else begin
                if (pv_awvalid && !p_aw &&
                    (!bus.m_axil_awvalid || bus.m_axil_awaddr !== pv_awaddr))
                    viol++;
                if (pv_wvalid && !p_w &&
                    (!bus.m_axil_wvalid || bus.m_axil_wdata !== pv_wdata))
                    viol++;
                if (pv_arvalid && !p_ar &&
                    (!bus.m_axil_arvalid || bus.m_axil_araddr !== pv_araddr))
                    viol++;
                if (p_aw) begin aw_got = 1; last_awaddr = pv_awaddr; end
                if (p_w)  begin w_got = 1;  last_wdata = pv_wdata;   end
                if (p_ar) begin ar_got = 1; last_araddr = pv_araddr; end
                if (p_b) begin
                    bus.m_axil_bvalid = 0; aw_got = 0; w_got = 0;
                    bwait = 0; b_hs++;
                end
                if (p_r) begin
                    bus.m_axil_rvalid = 0; ar_got = 0; rwait = 0; r_hs++;
                end
                if ((aw_got || w_got) && bus.m_axil_arvalid) viol++;
                if (ar_got && (bus.m_axil_awvalid || bus.m_axil_wvalid)) viol++;
                if (bus.m_axil_bready && !(aw_got && w_got)) viol++;
                if (bus.m_axil_rready && !ar_got) viol++;
                if (aw_got && w_got && !bus.m_axil_bvalid) begin
                    if (bwait >= b_dly) begin
                        bus.m_axil_bvalid = 1;
                        bus.m_axil_bresp = bresp_cfg;
                        if (bresp_cfg == 2'b00) slv_mem[last_awaddr] = last_wdata;
                    end else bwait++;
                end
                if (ar_got && !bus.m_axil_rvalid) begin
                    if (rwait >= r_dly) begin
                        bus.m_axil_rvalid = 1;
                        bus.m_axil_rresp = rresp_cfg;
                        bus.m_axil_rdata = slv_mem.exists(last_araddr) ?
                            slv_mem[last_araddr] : dflt(last_araddr);
                    end else rwait++;
                end
                if (bus.m_axil_awvalid) begin
                    bus.m_axil_awready = (aw_cnt >= aw_dly); aw_cnt++;
                end else begin
                    bus.m_axil_awready = 0; aw_cnt = 0;
                end
                if (bus.m_axil_wvalid) begin
                    bus.m_axil_wready = (w_cnt >= w_dly); w_cnt++;
                end else begin
                    bus.m_axil_wready = 0; w_cnt = 0;
                end
                if (bus.m_axil_arvalid) begin
                    bus.m_axil_arready = (ar_cnt >= ar_dly); ar_cnt++;
                    ar_high++;
                end else begin
                    bus.m_axil_arready = 0; ar_cnt = 0;
                end
                pv_awvalid = bus.m_axil_awvalid; pv_awaddr = bus.m_axil_awaddr;
                pv_wvalid  = bus.m_axil_wvalid;  pv_wdata  = bus.m_axil_wdata;
                pv_arvalid = bus.m_axil_arvalid; pv_araddr = bus.m_axil_araddr;
                p_aw = bus.m_axil_awvalid && bus.m_axil_awready;
                p_w  = bus.m_axil_wvalid && bus.m_axil_wready;
                p_ar = bus.m_axil_arvalid && bus.m_axil_arready;
                p_b  = bus.m_axil_bvalid && bus.m_axil_bready;
                p_r  = bus.m_axil_rvalid && bus.m_axil_rready;
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] a,
                         input logic [31:0] d);
        int n;
        @(negedge clk);
        bus.cmd_valid = 1; bus.cmd_we = we;
        bus.cmd_addr = a;  bus.cmd_wdata = d;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", n < 50, 1);
        acc = cyc;
        @(negedge clk);
        bus.cmd_valid = 0;
        bus.cmd_addr = $urandom;
        bus.cmd_wdata = $urandom;
        bus.cmd_we = $urandom_range(0, 1);
    endtask

    task automatic finish_txn(input logic we, input logic [31:0] a,
                              input logic [31:0] d, input int hold,
                              input bit chk_lat);
        int n;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        exp_data = we ? 32'h0 : (ref_mem.exists(a) ? ref_mem[a] : dflt(a));
        exp_resp = we ? bresp_cfg : rresp_cfg;
        n = 0;
        while (!bus.rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rsp_timeout", n < 100, 1);
        if (chk_lat) check("rsp_latency", cyc - acc, 3);
        check("rsp_we", bus.rsp_we, we);
        check("rsp_data", bus.rsp_data, exp_data);
        check("rsp_resp", bus.rsp_resp, exp_resp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_cmd_ready", bus.cmd_ready, 0);
            check("hold_data", bus.rsp_data, exp_data);
            check("hold_resp", bus.rsp_resp, exp_resp);
        end
        bus.rsp_ready = 1;
        @(negedge clk);
        bus.rsp_ready = 0;
        check("rsp_drop", bus.rsp_valid, 0);
        check("idle_ready", bus.cmd_ready, 1);
        if (we) begin
            check("awaddr_pass", last_awaddr, a);
            check("wdata_pass", last_wdata, d);
        end else begin
            check("araddr_pass", last_araddr, a);
        end
        if (we && bresp_cfg == 2'b00) ref_mem[a] = d;
    endtask

    task automatic set_dly(input int aw, input int w, input int ar,
                           input int b, input int r);
        aw_dly = aw; w_dly = w; ar_dly = ar; b_dly = b; r_dly = r;
    endtask

    initial begin
        int n, b0, acc_n, rsp_n, hs0;
        logic we, tog;
        logic [31:0] a, d;
        tests = 0; fails = 0;
        rst = 0;
        bus.cmd_valid = 0; bus.cmd_we = 0;
        bus.cmd_addr = 0;  bus.cmd_wdata = 0;
        bus.rsp_ready = 0;
        set_dly(0, 0, 0, 0, 0);
        bresp_cfg = 0; rresp_cfg = 0;
        slv_mem[32'h24] = 32'h1234_5678;
        ref_mem[32'h24] = 32'h1234_5678;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_valids", {bus.m_axil_awvalid, bus.m_axil_wvalid,
              bus.m_axil_arvalid, bus.m_axil_bready, bus.m_axil_rready,
              bus.rsp_valid}, 0);
        check("rst_rsp", {bus.rsp_we, bus.rsp_resp, bus.rsp_data}, 0);
        check("rst_addr", {bus.m_axil_awaddr, bus.m_axil_araddr}, 0);
        check("rst_wdata", bus.m_axil_wdata, 0);
        rst = 1;
        #1;
        check("release_cmd_ready", bus.cmd_ready, 1);

        // zero-wait write
        issue(1, 32'h10, 32'hDEAD_BEEF);
        check("w1_awvalid", bus.m_axil_awvalid, 1);
        check("w1_wvalid", bus.m_axil_wvalid, 1);
        check("w1_wstrb", bus.m_axil_wstrb, 4'hF);
        check("w1_awaddr", bus.m_axil_awaddr, 32'h10);
        check("w1_wdata", bus.m_axil_wdata, 32'hDEAD_BEEF);
        finish_txn(1, 32'h10, 32'hDEAD_BEEF, 0, 1);

        // read with arready delayed three cycles
        set_dly(0, 0, 3, 0, 0);
        ar_high = 0;
        issue(0, 32'h24, 0);
        finish_txn(0, 32'h24, 0, 0, 0);
        check("ar_held_cycles", ar_high, 4);
        check("rd_known_data", last_araddr == 32'h24, 1);

        // AW before W, then W before AW
        for (int k = 0; k < 2; k++) begin
            if (k == 0) set_dly(0, 2, 0, 0, 0);
            else set_dly(2, 0, 0, 0, 0);
            b0 = b_hs;
            issue(1, 32'h30 + 32'(k * 4), 32'hA000_0000 + 32'(k));
            @(negedge clk);
            check("split_awvalid", bus.m_axil_awvalid, k == 1);
            check("split_wvalid", bus.m_axil_wvalid, k == 0);
            finish_txn(1, 32'h30 + 32'(k * 4), 32'hA000_0000 + 32'(k), 0, 0);
            check("split_one_b", b_hs - b0, 1);
        end

        // SLVERR read with response back-pressure
        set_dly(0, 0, 0, 0, 1);
        rresp_cfg = 2'b10;
        issue(0, 32'h18, 0);
        finish_txn(0, 32'h18, 0, 5, 0);
        rresp_cfg = 2'b00;

        // reset while waiting for B
        set_dly(0, 0, 0, 20, 0);
        issue(1, 32'h28, 32'h5555_AAAA);
        n = 0;
        while (!bus.m_axil_bready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bready_seen", n < 50, 1);
        #2 rst = 0;
        #1;
        check("async_rst_valids", {bus.m_axil_awvalid, bus.m_axil_wvalid,
              bus.m_axil_arvalid, bus.m_axil_bready, bus.m_axil_rready,
              bus.rsp_valid}, 0);
        check("async_rst_cmd_ready", bus.cmd_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1;
        set_dly(0, 0, 0, 0, 0);
        issue(0, 32'h24, 0);
        finish_txn(0, 32'h24, 0, 0, 1);

        // randomized traffic
        for (int t = 0; t < 30; t++) begin
            we = 1'($urandom_range(0, 1));
            a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            d = $urandom;
            set_dly($urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3));
            n = $urandom_range(0, 3);
            bresp_cfg = (n == 3) ? 2'b11 : (n == 2) ? 2'b10 : 2'b00;
            n = $urandom_range(0, 3);
            rresp_cfg = (n == 3) ? 2'b11 : (n == 2) ? 2'b10 : 2'b00;
            issue(we, a, d);
            finish_txn(we, a, d, $urandom_range(0, 2), 0);
        end
        bresp_cfg = 0; rresp_cfg = 0;
        set_dly(0, 0, 0, 0, 0);

        // back-to-back with cmd_valid and rsp_ready held high
        @(negedge clk);
        bus.cmd_valid = 1; bus.cmd_we = 0;
        bus.cmd_addr = 32'h3C; bus.cmd_wdata = 32'hC0DE_0000;
        bus.rsp_ready = 1;
        acc_n = 0; rsp_n = 0; hs0 = b_hs + r_hs;
        for (int i = 0; i < 40; i++) begin
            tog = bus.cmd_ready;
            if (bus.cmd_ready) acc_n++;
            if (bus.rsp_valid) rsp_n++;
            @(negedge clk);
            if (tog) bus.cmd_we = ~bus.cmd_we;
        end
        bus.cmd_valid = 0;
        repeat (3) @(negedge clk);
        bus.rsp_ready = 0;
        check("b2b_accepts", acc_n, 10);
        check("b2b_responses", rsp_n, 10);
        check("b2b_axi_resps", b_hs + r_hs - hs0, 10);
        check("proto_violations", viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
